// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, grant owner and transfer size codes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    ERR  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_D    = 2'd2
  } arb_gnt_e;

  localparam logic [2:0] SZ_BYTE   = 3'b000;
  localparam logic [2:0] SZ_HALF   = 3'b001;
  localparam logic [2:0] SZ_WORD   = 3'b010;
  localparam logic [2:0] SZ_BYTE_U = 3'b100;
  localparam logic [2:0] SZ_HALF_U = 3'b101;

endpackage

// File: rtl/mem_arb_timeout.sv
// Access watchdog: counts cycles while an access is in flight and flags when the
// limit is reached. Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] count_q;

  // expired is asserted during the TIMEOUT_CYCLES-th cycle of the access
  assign expired = run && (count_q == Limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (run && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one single-port memory, data side first.
// Optional access watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_type,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_type,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        arb_err
);

  arb_state_e state_q;
  arb_gnt_e   gnt_q;
  logic       done;
  logic       timeout_hit;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (CLK),
    .rst    (rst),
    .clear  (state_q == IDLE),
    .run    ((state_q == REQ) || (state_q == WAIT)),
    .expired(timeout_hit)
  );
`else
  // Watchdog absent: the parameter is accepted but has no effect.
  assign timeout_hit = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  // A ready+rvalid pair in REQ completes the access without visiting WAIT.
  assign done = ((state_q == REQ) && mem_ready && mem_rvalid) ||
                ((state_q == WAIT) && mem_rvalid);

  assign cpu_stall = (if_req && !if_valid) || (d_req && !d_valid) || (state_q == ERR);

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= GNT_NONE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_type  <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      d_rdata   <= '0;
      d_valid   <= 1'b0;
      arb_err   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state_q)
        IDLE: begin
          // The completion cycle is spent here; the finished requester still holds req.
          if (!if_valid && !d_valid) begin
            if (d_req) begin
              gnt_q     <= GNT_D;
              mem_req   <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_type  <= d_type;
              state_q   <= REQ;
            end else if (if_req) begin
              gnt_q     <= GNT_IF;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_type  <= SZ_WORD;
              state_q   <= REQ;
            end
          end
        end
        REQ, WAIT: begin
          if (done) begin
            state_q <= IDLE;
            mem_req <= 1'b0;
            gnt_q   <= GNT_NONE;
            if (gnt_q == GNT_D) begin
              d_valid <= 1'b1;
              d_rdata <= mem_rdata;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (timeout_hit) begin
            state_q <= ERR;
            mem_req <= 1'b0;
            gnt_q   <= GNT_NONE;
            arb_err <= 1'b1;
          end else if ((state_q == REQ) && mem_ready) begin
            state_q <= WAIT;
            mem_req <= 1'b0;
          end
        end
        ERR: begin
          state_q <= ERR;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; timeout scenario follows MEM_ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_type;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_type;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        arb_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_type    (d_type),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_type  (mem_type),
    .mem_ready (mem_ready),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .arb_err   (arb_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    if (mem_req !== 1'b0) begin $display("FAIL reset_mem_req: got %b want 0", mem_req); miscompares++; end vectors++;
    if (if_valid !== 1'b0) begin $display("FAIL reset_if_valid: got %b want 0", if_valid); miscompares++; end vectors++;
    if (d_valid !== 1'b0) begin $display("FAIL reset_d_valid: got %b want 0", d_valid); miscompares++; end vectors++;
    if (arb_err !== 1'b0) begin $display("FAIL reset_arb_err: got %b want 0", arb_err); miscompares++; end vectors++;
    if (cpu_stall !== 1'b0) begin $display("FAIL reset_stall: got %b want 0", cpu_stall); miscompares++; end vectors++;
    if (mem_addr !== 32'h0) begin $display("FAIL reset_mem_addr: got %h want 0", mem_addr); miscompares++; end vectors++;
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    step();
    if_req = 1'b1; if_addr = 32'h100; #1;
    if (cpu_stall !== 1'b1) begin $display("FAIL fetch_stall_n: got %b want 1", cpu_stall); miscompares++; end vectors++;
    step(); #1;
    if (mem_req !== 1'b1) begin $display("FAIL fetch_mem_req_n1: got %b want 1", mem_req); miscompares++; end vectors++;
    if (mem_addr !== 32'h100) begin $display("FAIL fetch_mem_addr: got %h want 00000100", mem_addr); miscompares++; end vectors++;
    if (mem_we !== 1'b0) begin $display("FAIL fetch_mem_we: got %b want 0", mem_we); miscompares++; end vectors++;
    if (mem_type !== SZ_WORD) begin $display("FAIL fetch_mem_type: got %b want 010", mem_type); miscompares++; end vectors++;
    step();
    mem_ready = 1'b1; #1;
    if (mem_req !== 1'b1) begin $display("FAIL fetch_mem_req_n2: got %b want 1", mem_req); miscompares++; end vectors++;
    step();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00A00093; #1;
    if (mem_req !== 1'b0) begin $display("FAIL fetch_mem_req_n3: got %b want 0", mem_req); miscompares++; end vectors++;
    if (if_valid !== 1'b0) begin $display("FAIL fetch_if_valid_n3: got %b want 0", if_valid); miscompares++; end vectors++;
    step();
    mem_rvalid = 1'b0; mem_rdata = 32'h0; #1;
    if (if_valid !== 1'b1) begin $display("FAIL fetch_if_valid_n4: got %b want 1", if_valid); miscompares++; end vectors++;
    if (if_rdata !== 32'h00A00093) begin $display("FAIL fetch_if_rdata: got %h want 00a00093", if_rdata); miscompares++; end vectors++;
    if (cpu_stall !== 1'b0) begin $display("FAIL fetch_stall_n4: got %b want 0", cpu_stall); miscompares++; end vectors++;
    if (d_valid !== 1'b0) begin $display("FAIL fetch_d_valid: got %b want 0", d_valid); miscompares++; end vectors++;
    step();
    if_req = 1'b0; #1;
    if (if_valid !== 1'b0) begin $display("FAIL fetch_if_valid_n5: got %b want 0", if_valid); miscompares++; end vectors++;
    if (mem_req !== 1'b0) begin $display("FAIL fetch_no_reissue_n5: got %b want 0", mem_req); miscompares++; end vectors++;
    step(); #1;
    if (mem_req !== 1'b0) begin $display("FAIL fetch_no_reissue_n6: got %b want 0", mem_req); miscompares++; end vectors++;
  endtask

  task automatic test_priority();
    step();
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_type = SZ_WORD; #1;
    if (cpu_stall !== 1'b1) begin $display("FAIL prio_stall_n: got %b want 1", cpu_stall); miscompares++; end vectors++;
    step();
    mem_ready = 1'b1; #1;
    if (mem_req !== 1'b1) begin $display("FAIL prio_mem_req: got %b want 1", mem_req); miscompares++; end vectors++;
    if (mem_we !== 1'b1) begin $display("FAIL prio_mem_we: got %b want 1", mem_we); miscompares++; end vectors++;
    if (mem_addr !== 32'h2000) begin $display("FAIL prio_mem_addr: got %h want 00002000", mem_addr); miscompares++; end vectors++;
    if (mem_wdata !== 32'hDEADBEEF) begin $display("FAIL prio_mem_wdata: got %h want deadbeef", mem_wdata); miscompares++; end vectors++;
    if (mem_type !== SZ_WORD) begin $display("FAIL prio_mem_type: got %b want 010", mem_type); miscompares++; end vectors++;
    step();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0; #1;
    if (mem_req !== 1'b0) begin $display("FAIL prio_wait_mem_req: got %b want 0", mem_req); miscompares++; end vectors++;
    step();
    mem_rvalid = 1'b0; #1;
    if (d_valid !== 1'b1) begin $display("FAIL prio_d_valid: got %b want 1", d_valid); miscompares++; end vectors++;
    if (if_valid !== 1'b0) begin $display("FAIL prio_if_valid_early: got %b want 0", if_valid); miscompares++; end vectors++;
    if (cpu_stall !== 1'b1) begin $display("FAIL prio_stall_fetch_pending: got %b want 1", cpu_stall); miscompares++; end vectors++;
    step();
    d_req = 1'b0; d_we = 1'b0; #1;
    if (mem_req !== 1'b0) begin $display("FAIL prio_idle_gap: got %b want 0", mem_req); miscompares++; end vectors++;
    step(); #1;
    if (mem_req !== 1'b1) begin $display("FAIL prio_fetch_req: got %b want 1", mem_req); miscompares++; end vectors++;
    if (mem_addr !== 32'h200) begin $display("FAIL prio_fetch_addr: got %h want 00000200", mem_addr); miscompares++; end vectors++;
    if (mem_we !== 1'b0) begin $display("FAIL prio_fetch_we: got %b want 0", mem_we); miscompares++; end vectors++;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_ready = 1'b0; mem_rvalid = 1'b0; #1;
    if (if_valid !== 1'b1) begin $display("FAIL prio_if_valid: got %b want 1", if_valid); miscompares++; end vectors++;
    if (if_rdata !== 32'hCAFEF00D) begin $display("FAIL prio_if_rdata: got %h want cafef00d", if_rdata); miscompares++; end vectors++;
    if (d_valid !== 1'b0) begin $display("FAIL prio_d_valid_late: got %b want 0", d_valid); miscompares++; end vectors++;
    step();
    if_req = 1'b0;
  endtask

  task automatic test_same_cycle();
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_type = SZ_WORD;
    step(); #1;
    if (mem_req !== 1'b1) begin $display("FAIL same_mem_req: got %b want 1", mem_req); miscompares++; end vectors++;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    step();
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; #1;
    if (d_valid !== 1'b1) begin $display("FAIL same_d_valid: got %b want 1", d_valid); miscompares++; end vectors++;
    if (d_rdata !== 32'h12345678) begin $display("FAIL same_d_rdata: got %h want 12345678", d_rdata); miscompares++; end vectors++;
    if (mem_req !== 1'b0) begin $display("FAIL same_mem_req_off: got %b want 0", mem_req); miscompares++; end vectors++;
    if (cpu_stall !== 1'b0) begin $display("FAIL same_stall: got %b want 0", cpu_stall); miscompares++; end vectors++;
    step();
    d_req = 1'b0; #1;
    if (d_valid !== 1'b0) begin $display("FAIL same_d_valid_once: got %b want 0", d_valid); miscompares++; end vectors++;
  endtask

  task automatic test_spurious();
    step();
    mem_rvalid = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
    step(); #1;
    if (if_valid !== 1'b0) begin $display("FAIL spur_if_valid: got %b want 0", if_valid); miscompares++; end vectors++;
    if (d_valid !== 1'b0) begin $display("FAIL spur_d_valid: got %b want 0", d_valid); miscompares++; end vectors++;
    if (mem_req !== 1'b0) begin $display("FAIL spur_mem_req: got %b want 0", mem_req); miscompares++; end vectors++;
    step();
    mem_rvalid = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0; #1;
    if ((if_valid | d_valid) !== 1'b0) begin $display("FAIL spur_valid_late: got %b want 0", if_valid | d_valid); miscompares++; end vectors++;
    if (d_rdata !== 32'h12345678) begin $display("FAIL spur_d_rdata_kept: got %h want 12345678", d_rdata); miscompares++; end vectors++;
  endtask

  task automatic test_reset_mid();
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_type = SZ_WORD;
    step();
    mem_ready = 1'b1; #1;
    if (mem_req !== 1'b1) begin $display("FAIL rstmid_mem_req: got %b want 1", mem_req); miscompares++; end vectors++;
    step();
    mem_ready = 1'b0; rst = 1'b1; d_req = 1'b0; #1;
    if (mem_req !== 1'b0) begin $display("FAIL rstmid_wait: got %b want 0", mem_req); miscompares++; end vectors++;
    step();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55; #1;
    if (mem_addr !== 32'h0) begin $display("FAIL rstmid_mem_addr: got %h want 0", mem_addr); miscompares++; end vectors++;
    if (d_rdata !== 32'h0) begin $display("FAIL rstmid_d_rdata: got %h want 0", d_rdata); miscompares++; end vectors++;
    step();
    mem_rvalid = 1'b0; mem_rdata = 32'h0; #1;
    if (d_valid !== 1'b0) begin $display("FAIL rstmid_d_valid: got %b want 0", d_valid); miscompares++; end vectors++;
    if (d_rdata !== 32'h0) begin $display("FAIL rstmid_d_rdata_late: got %h want 0", d_rdata); miscompares++; end vectors++;
    if (mem_req !== 1'b0) begin $display("FAIL rstmid_mem_req_late: got %b want 0", mem_req); miscompares++; end vectors++;
  endtask

  task automatic test_timeout();
    step();
    if_req = 1'b1; if_addr = 32'h400;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      step(); #1;
      if (k == 8 && arb_err !== 1'b0) begin $display("FAIL tmo_err_early: got %b want 0", arb_err); miscompares++; end
      if (k == 8 && mem_req !== 1'b1) begin $display("FAIL tmo_req_held: got %b want 1", mem_req); miscompares++; end
    end
    vectors += 2;
    step(); #1;
    if (arb_err !== 1'b1) begin $display("FAIL tmo_err: got %b want 1", arb_err); miscompares++; end vectors++;
    if (mem_req !== 1'b0) begin $display("FAIL tmo_mem_req: got %b want 0", mem_req); miscompares++; end vectors++;
    if (cpu_stall !== 1'b1) begin $display("FAIL tmo_stall: got %b want 1", cpu_stall); miscompares++; end vectors++;
    step();
    if_req = 1'b0; #1;
    if (cpu_stall !== 1'b1) begin $display("FAIL tmo_stall_sticky: got %b want 1", cpu_stall); miscompares++; end vectors++;
    if (arb_err !== 1'b1) begin $display("FAIL tmo_err_sticky: got %b want 1", arb_err); miscompares++; end vectors++;
`else
    for (int k = 1; k <= 12; k++) begin
      step();
    end
    #1;
    if (arb_err !== 1'b0) begin $display("FAIL notmo_err: got %b want 0", arb_err); miscompares++; end vectors++;
    if (mem_req !== 1'b1) begin $display("FAIL notmo_req_held: got %b want 1", mem_req); miscompares++; end vectors++;
    if (cpu_stall !== 1'b1) begin $display("FAIL notmo_stall: got %b want 1", cpu_stall); miscompares++; end vectors++;
    if_req = 1'b0;
`endif
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; #1;
    if (arb_err !== 1'b0) begin $display("FAIL tmo_rst_err: got %b want 0", arb_err); miscompares++; end vectors++;
    if (mem_req !== 1'b0) begin $display("FAIL tmo_rst_req: got %b want 0", mem_req); miscompares++; end vectors++;
    if (cpu_stall !== 1'b0) begin $display("FAIL tmo_rst_stall: got %b want 0", cpu_stall); miscompares++; end vectors++;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_type = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step();
    step();
    test_reset();
    test_fetch();
    test_priority();
    test_same_cycle();
    test_spurious();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
